pipe_hazard_ctrl: RTL and testbench

Next-generation pipeline hazard and stall/flush controller for the in-order core, sitting between the ID, EX and WB stage registers. It adds several capabilities:
- parametrised register-address width;
- dual-stage load-use detection (EX and MEM) with x0 exemption and per-operand use flags;
- a sequencer that stalls on multi-cycle MUL/DIV;
- fence.i handling that drains the store buffer and then runs an I-cache invalidate handshake;
- a multi-cycle flush window on exception/interrupt.

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller between the ID, EX and WB stage registers of the in-order core.
// Optional perf counters are enabled with `define PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int RF_AW        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_is_bj_inst,
  input  logic             id_is_mret_inst,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RF_AW-1:0] id_rf_raddr1,
  input  logic [RF_AW-1:0] id_rf_raddr2,
  input  logic             ex_loading,
  input  logic [RF_AW-1:0] ex_rf_waddr,
  input  logic             mem_ld_pending,
  input  logic [RF_AW-1:0] mem_rf_waddr,
  input  logic             ex_mdu_start,
  input  logic             ex_mdu_done,
  input  logic             id_is_fence_i,
  input  logic             sb_empty,
  output logic             icache_inv_req,
  input  logic             icache_inv_ack,
  input  logic             wb_exp_int_flag,
  output logic             ld_risk,
  output logic             pipe_stall,
  output logic             pipe_flush,
  output logic [1:0]       ctrl_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_flush_events
`endif
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  if (FLUSH_CYCLES < 1 || PERF_CNT_W < 1 || RF_AW < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: FLUSH_CYCLES, PERF_CNT_W and RF_AW must all be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    MDU_WAIT    = 2'd1,
    FENCE_DRAIN = 2'd2,
    FENCE_INV   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] flush_cnt;
  logic          flush_raw;
  logic          hit_1;
  logic          hit_2;
  logic          mdu_begin;
  logic          idle_fence;
  logic          stall_gated;
  logic          stall_inv;

  // Register x0 never carries a dependency, so it is exempt from load-use checks.
  assign hit_1 = id_use_rs1 && (id_rf_raddr1 != '0) &&
                 ((ex_loading && (ex_rf_waddr == id_rf_raddr1)) ||
                  (mem_ld_pending && (mem_rf_waddr == id_rf_raddr1)));
  assign hit_2 = id_use_rs2 && (id_rf_raddr2 != '0) &&
                 ((ex_loading && (ex_rf_waddr == id_rf_raddr2)) ||
                  (mem_ld_pending && (mem_rf_waddr == id_rf_raddr2)));

  assign flush_raw  = wb_exp_int_flag || (flush_cnt != '0);
  assign mdu_begin  = (state == IDLE) && ex_mdu_start && !ex_mdu_done;
  assign idle_fence = (state == IDLE) && id_is_fence_i;

  assign stall_gated = id_is_bj_inst || id_is_mret_inst || hit_1 || hit_2 ||
                       mdu_begin || idle_fence ||
                       ((state == MDU_WAIT) && !ex_mdu_done) ||
                       (state == FENCE_DRAIN);
  // An invalidate in flight must complete even across a flush, so this term bypasses the gate.
  assign stall_inv   = (state == FENCE_INV) && !icache_inv_ack;

  assign pipe_flush = rst_n && flush_raw;
  assign ld_risk    = rst_n && (hit_1 || hit_2) && !flush_raw;
  assign pipe_stall = rst_n && ((stall_gated && !flush_raw) || stall_inv);
  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (wb_exp_int_flag) begin
      flush_cnt <= CW'(FLUSH_CYCLES - 1);
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      icache_inv_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A flushed instruction in ID/EX must not launch a sequence.
          if (!flush_raw) begin
            if (ex_mdu_start && !ex_mdu_done) begin
              state <= MDU_WAIT;
            end else if (id_is_fence_i) begin
              state <= FENCE_DRAIN;
            end
          end
        end
        MDU_WAIT: begin
          if (flush_raw || ex_mdu_done) begin
            state <= IDLE;
          end
        end
        FENCE_DRAIN: begin
          if (flush_raw) begin
            state <= IDLE;
          end else if (sb_empty) begin
            state          <= FENCE_INV;
            icache_inv_req <= 1'b1;
          end
        end
        FENCE_INV: begin
          if (icache_inv_ack) begin
            state          <= IDLE;
            icache_inv_req <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          icache_inv_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic wb_flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_flag_q         <= 1'b0;
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      wb_flag_q <= wb_exp_int_flag;
      if (pipe_stall && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + PERF_CNT_W'(1);
      end
      if (wb_exp_int_flag && !wb_flag_q && (perf_flush_events != '1)) begin
        perf_flush_events <= perf_flush_events + PERF_CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: load-use vector table plus scoreboarded multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_is_bj_inst, id_is_mret_inst, id_use_rs1, id_use_rs2;
  logic [4:0] id_rf_raddr1, id_rf_raddr2, ex_rf_waddr, mem_rf_waddr;
  logic       ex_loading, mem_ld_pending, ex_mdu_start, ex_mdu_done;
  logic       id_is_fence_i, sb_empty, icache_inv_req, icache_inv_ack;
  logic       wb_exp_int_flag, ld_risk, pipe_stall, pipe_flush;
  logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0] perf_stall_cycles, perf_flush_events;
`endif

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.RF_AW(5), .FLUSH_CYCLES(3), .PERF_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_is_bj_inst(id_is_bj_inst), .id_is_mret_inst(id_is_mret_inst),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rf_raddr1(id_rf_raddr1), .id_rf_raddr2(id_rf_raddr2),
    .ex_loading(ex_loading), .ex_rf_waddr(ex_rf_waddr),
    .mem_ld_pending(mem_ld_pending), .mem_rf_waddr(mem_rf_waddr),
    .ex_mdu_start(ex_mdu_start), .ex_mdu_done(ex_mdu_done),
    .id_is_fence_i(id_is_fence_i), .sb_empty(sb_empty),
    .icache_inv_req(icache_inv_req), .icache_inv_ack(icache_inv_ack),
    .wb_exp_int_flag(wb_exp_int_flag), .ld_risk(ld_risk),
    .pipe_stall(pipe_stall), .pipe_flush(pipe_flush), .ctrl_state(ctrl_state)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       ld, st, fl, rq;
    logic [1:0] cs;
  } exp_t;

  typedef struct {
    logic       u1, u2;
    logic [4:0] a1, a2;
    logic       exld;
    logic [4:0] exw;
    logic       memp;
    logic [4:0] memw;
    logic       bj, mret;
    logic       e_ld, e_st;
  } vec_t;

  exp_t sb[$];
  vec_t vt[11];

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, fld, act, exp, $time);
    end
  endtask

  // Push expectation for the current cycle, compare on the falling edge, then advance.
  task automatic cyc(input string nm, input logic ld, input logic st, input logic fl,
                     input logic rq, input logic [1:0] cs);
    exp_t e;
    e.nm = nm; e.ld = ld; e.st = st; e.fl = fl; e.rq = rq; e.cs = cs;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.nm, "ld_risk", 32'(ld_risk), 32'(e.ld));
    chk(e.nm, "pipe_stall", 32'(pipe_stall), 32'(e.st));
    chk(e.nm, "pipe_flush", 32'(pipe_flush), 32'(e.fl));
    chk(e.nm, "icache_inv_req", 32'(icache_inv_req), 32'(e.rq));
    chk(e.nm, "ctrl_state", 32'(ctrl_state), 32'(e.cs));
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_is_bj_inst = 0; id_is_mret_inst = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rf_raddr1 = 0; id_rf_raddr2 = 0; ex_loading = 0; ex_rf_waddr = 0;
    mem_ld_pending = 0; mem_rf_waddr = 0; ex_mdu_start = 0; ex_mdu_done = 0;
    id_is_fence_i = 0; sb_empty = 1; icache_inv_ack = 0; wb_exp_int_flag = 0;
  endtask

  initial begin
    //           u1 u2 a1 a2 exld exw memp memw bj mret e_ld e_st
    vt[0]  = '{0, 1, 0, 5, 1, 5, 0, 0, 0, 0, 1, 1};
    vt[1]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 5, 1, 5, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 1, 0, 5, 0, 0, 1, 5, 0, 0, 1, 1};
    vt[4]  = '{1, 0, 7, 0, 1, 7, 0, 0, 0, 0, 1, 1};
    vt[5]  = '{1, 0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vt[8]  = '{1, 0, 3, 0, 0, 0, 1, 4, 0, 0, 0, 0};
    vt[9]  = '{1, 1, 3, 9, 0, 0, 1, 9, 0, 0, 1, 1};
    vt[10] = '{1, 1, 3, 9, 1, 3, 1, 9, 0, 0, 1, 1};

    clr();
    rst_n = 0;
    @(posedge clk); #1;
    wb_exp_int_flag = 1; id_is_bj_inst = 1; ex_mdu_start = 1;
    cyc("reset", 0, 0, 0, 0, 0);
    cyc("reset", 0, 0, 0, 0, 0);
    rst_n = 1; clr();
    cyc("idle", 0, 0, 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      id_use_rs1 = vt[i].u1; id_use_rs2 = vt[i].u2;
      id_rf_raddr1 = vt[i].a1; id_rf_raddr2 = vt[i].a2;
      ex_loading = vt[i].exld; ex_rf_waddr = vt[i].exw;
      mem_ld_pending = vt[i].memp; mem_rf_waddr = vt[i].memw;
      id_is_bj_inst = vt[i].bj; id_is_mret_inst = vt[i].mret;
      cyc($sformatf("ldu_vec%0d", i), vt[i].e_ld, vt[i].e_st, 0, 0, 0);
    end
    clr();

    // MUL/DIV: start at cycle 0, done at cycle 33
    ex_mdu_start = 1;
    cyc("mdu_start", 0, 1, 0, 0, 0);
    ex_mdu_start = 0;
    for (int i = 1; i <= 32; i++) cyc("mdu_wait", 0, 1, 0, 0, 1);
    ex_mdu_done = 1;
    cyc("mdu_done", 0, 0, 0, 0, 1);
    ex_mdu_done = 0;
    cyc("mdu_after", 0, 0, 0, 0, 0);
    ex_mdu_start = 1; ex_mdu_done = 1;
    cyc("mdu_same", 0, 0, 0, 0, 0);
    clr();
    cyc("mdu_same_after", 0, 0, 0, 0, 0);

    // fence.i: drain, invalidate handshake
    id_is_fence_i = 1; sb_empty = 0;
    cyc("fence_enter", 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cyc("fence_drain", 0, 1, 0, 0, 2);
    sb_empty = 1;
    cyc("fence_drain_last", 0, 1, 0, 0, 2);
    for (int i = 0; i < 3; i++) cyc("fence_inv", 0, 1, 0, 1, 3);
    icache_inv_ack = 1;
    cyc("fence_ack", 0, 0, 0, 1, 3);
    clr();
    cyc("fence_done", 0, 0, 0, 0, 0);

    // Flush during MDU_WAIT
    ex_mdu_start = 1;
    cyc("fl_mdu_start", 0, 1, 0, 0, 0);
    ex_mdu_start = 0;
    cyc("fl_mdu_wait", 0, 1, 0, 0, 1);
    wb_exp_int_flag = 1;
    cyc("fl_mdu_flag", 0, 0, 1, 0, 1);
    wb_exp_int_flag = 0;
    ex_loading = 1; ex_rf_waddr = 5; id_use_rs2 = 1; id_rf_raddr2 = 5;
    cyc("fl_mdu_win_ldu", 0, 0, 1, 0, 0);
    clr();
    cyc("fl_mdu_win", 0, 0, 1, 0, 0);
    cyc("fl_mdu_end", 0, 0, 0, 0, 0);

    // Re-asserted flag extends the window to 5 cycles
    wb_exp_int_flag = 1;
    cyc("fl_ext0", 0, 0, 1, 0, 0);
    wb_exp_int_flag = 0;
    cyc("fl_ext1", 0, 0, 1, 0, 0);
    wb_exp_int_flag = 1;
    cyc("fl_ext2", 0, 0, 1, 0, 0);
    wb_exp_int_flag = 0;
    cyc("fl_ext3", 0, 0, 1, 0, 0);
    cyc("fl_ext4", 0, 0, 1, 0, 0);
    cyc("fl_ext5", 0, 0, 0, 0, 0);

    // Flush in IDLE blocks fence.i and MDU launch
    wb_exp_int_flag = 1; id_is_fence_i = 1; ex_mdu_start = 1;
    cyc("fl_idle_fence", 0, 0, 1, 0, 0);
    clr();
    cyc("fl_idle_after", 0, 0, 1, 0, 0);
    cyc("fl_idle_after", 0, 0, 1, 0, 0);
    cyc("fl_idle_end", 0, 0, 0, 0, 0);

    // Flush during FENCE_INV never aborts the handshake
    id_is_fence_i = 1;
    cyc("fi_enter", 0, 1, 0, 0, 0);
    cyc("fi_drain", 0, 1, 0, 0, 2);
    id_is_fence_i = 0;
    cyc("fi_inv", 0, 1, 0, 1, 3);
    wb_exp_int_flag = 1;
    cyc("fi_flag", 0, 1, 1, 1, 3);
    wb_exp_int_flag = 0;
    cyc("fi_hold", 0, 1, 1, 1, 3);
    icache_inv_ack = 1;
    cyc("fi_ack", 0, 0, 1, 1, 3);
    clr();
    cyc("fi_done", 0, 0, 0, 0, 0);

    // Asynchronous reset mid-MDU_WAIT
    ex_mdu_start = 1;
    cyc("rm_start", 0, 1, 0, 0, 0);
    ex_mdu_start = 0;
    cyc("rm_wait", 0, 1, 0, 0, 1);
    rst_n = 0; wb_exp_int_flag = 1; id_is_bj_inst = 1;
    cyc("rm_reset", 0, 0, 0, 0, 0);
    rst_n = 1; clr();
    cyc("rm_idle", 0, 0, 0, 0, 0);

`ifdef PIPE_PERF_CNT_EN
    id_is_bj_inst = 1;
    for (int i = 0; i < 20; i++) cyc("perf_stall", 0, 1, 0, 0, 0);
    clr();
    chk("perf", "perf_stall_cycles", 32'(perf_stall_cycles), 32'd15);
`endif

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
